// File: rtl/key_seq_pkg.sv
// key_seq_pkg: sequencer state encoding and active-low key levels
package key_seq_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, PRESS, RELEASE, FINISH, FAIL} state_t;
  localparam logic KEY_PRESSED = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;
endpackage

// File: rtl/key_seq_timer.sv
// key_seq_timer: loadable down-counter flagging expiry at zero
module key_seq_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - W'(1);
  assign o_expired = r_cnt == '0;
endmodule

// File: rtl/key_sequencer.sv
// key_sequencer: presses up/down keys until the counter feedback reaches the latched target
module key_sequencer
  import key_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PRESS_CYCLES = 4,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] count,
  output logic             Key1,
  output logic             Key2,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] steps
);
  localparam int TW = $clog2(PRESS_CYCLES > RELEASE_CYCLES ? PRESS_CYCLES : RELEASE_CYCLES);
  localparam logic [TW-1:0] PRESS_VAL = TW'(PRESS_CYCLES - 1);
  localparam logic [TW-1:0] RELEASE_VAL = TW'(RELEASE_CYCLES - 1);
  localparam logic [WIDTH-1:0] STEP_MAX = {WIDTH{1'b1}};
  state_t r_state, w_next;
  logic r_up, w_up, w_load, w_en, w_expired, w_accept;
  logic [TW-1:0] w_load_val;
  logic [WIDTH-1:0] r_target, r_steps;
  logic r_key1, r_key2, r_busy, r_done, r_error;
  key_seq_timer #(.W(TW)) u_timer (
    .clk       (clock),
    .rst       (reset),
    .i_load    (w_load),
    .i_en      (w_en),
    .i_load_val(w_load_val),
    .o_expired (w_expired)
  );
  // busy stays high through the done/error cycle, so it also gates acceptance in IDLE
  assign w_accept = r_state == IDLE && start && !r_busy;
  always_comb begin
    w_next = r_state;
    w_up = r_up;
    w_load = 1'b0;
    w_en = 1'b0;
    w_load_val = '0;
    case (r_state)
      IDLE: w_next = w_accept ? CHECK : IDLE;
      CHECK: begin
        if (count == r_target) w_next = FINISH;
        else if (r_steps == STEP_MAX) w_next = FAIL;
        else begin
          w_next = PRESS;
          w_up = r_target > count;
          w_load = 1'b1;
          w_load_val = PRESS_VAL;
        end
      end
      PRESS: begin
        w_en = 1'b1;
        w_next = w_expired ? RELEASE : PRESS;
        w_load = w_expired;
        w_load_val = RELEASE_VAL;
      end
      RELEASE: begin
        w_en = 1'b1;
        w_next = w_expired ? CHECK : RELEASE;
      end
      default: w_next = IDLE;
    endcase
  end
  // outputs are registered decodes of the current state, one cycle behind it
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_up <= 1'b0;
      r_target <= '0;
      r_steps <= '0;
      r_key1 <= KEY_RELEASED;
      r_key2 <= KEY_RELEASED;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_up <= w_up;
      if (w_accept) begin
        r_target <= target;
        r_steps <= '0;
      end else if (r_state == CHECK && w_next == PRESS) r_steps <= r_steps + WIDTH'(1);
      r_key1 <= (r_state == PRESS && r_up) ? KEY_PRESSED : KEY_RELEASED;
      r_key2 <= (r_state == PRESS && !r_up) ? KEY_PRESSED : KEY_RELEASED;
      r_busy <= r_state != IDLE || w_next != IDLE;
      r_done <= r_state == FINISH;
      r_error <= r_state == FAIL;
    end
  end
  assign Key1 = r_key1;
  assign Key2 = r_key2;
  assign busy = r_busy;
  assign done = r_done;
  assign error = r_error;
  assign steps = r_steps;
endmodule

// File: tb/tb_key_sequencer.sv
// tb_key_sequencer: directed closed-loop bench with a keyed up/down counter model
module tb_key_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] target = '0, m_count = '0, m_set_val = '0;
  logic m_set = 1'b0, m_freeze = 1'b0, m_armed = 1'b1;
  logic key1, key2, busy, done, error;
  logic [3:0] steps;
  int n_tests = 0, n_fail = 0;
  int dcyc, ecyc, ndone, nerr, p1, p2, low1, low2, bad, sdone, bend;

  key_sequencer dut (
    .clock (clk),
    .reset (rst),
    .start (start),
    .target(target),
    .count (m_count),
    .Key1  (key1),
    .Key2  (key2),
    .busy  (busy),
    .done  (done),
    .error (error),
    .steps (steps)
  );

  always #5 clk = ~clk;

  // one count step per press, re-armed only once both keys are released
  always @(posedge clk)
    if (m_set) begin
      m_count <= m_set_val;
      m_armed <= 1'b1;
    end else if (key1 && key2) m_armed <= 1'b1;
    else if (m_armed) begin
      m_armed <= 1'b0;
      if (!m_freeze) m_count <= !key1 ? m_count + 4'd1 : m_count - 4'd1;
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_count(input logic [3:0] v);
    @(negedge clk);
    m_set = 1'b1;
    m_set_val = v;
    @(negedge clk);
    m_set = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] tgt, input int limit, input int rs_cyc);
    logic pk1, pk2;
    dcyc = -1; ecyc = -1; ndone = 0; nerr = 0; p1 = 0; p2 = 0;
    low1 = 0; low2 = 0; bad = 0; sdone = -1; bend = -1;
    pk1 = 1'b1; pk2 = 1'b1;
    @(negedge clk);
    start = 1'b1;
    target = tgt;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int rel = 0; rel <= limit; rel++) begin
      if (rel > 0) @(negedge clk);
      if (pk1 && !key1) p1++;
      if (pk2 && !key2) p2++;
      if (!key1) low1++;
      if (!key2) low2++;
      if ((!key1 && !key2) || (done && error)) bad++;
      if (done) begin
        ndone++;
        if (dcyc < 0) begin dcyc = rel; sdone = steps; end
      end
      if (error) begin
        nerr++;
        if (ecyc < 0) ecyc = rel;
      end
      if (!busy && bend < 0) bend = rel;
      pk1 = key1;
      pk2 = key2;
      if (rel == rs_cyc) begin start = 1'b1; target = 4'd1; end
      if (rel == rs_cyc + 1) begin start = 1'b0; target = tgt; end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_key1", key1, 1);
    check("rst_key2", key2, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_steps", steps, 0);
    rst = 1'b0;

    set_count(4'd0);
    run_op(4'd5, 60, -1);
    check("up_done_cyc", dcyc, 47);
    check("up_ndone", ndone, 1);
    check("up_steps", sdone, 5);
    check("up_k1_pulses", p1, 5);
    check("up_k1_low", low1, 20);
    check("up_k2_pulses", p2, 0);
    check("up_busy_end", bend, 48);
    check("up_count", m_count, 5);
    check("up_bad", bad, 0);
    repeat (5) @(negedge clk);
    check("idle_steps_hold", steps, 5);

    set_count(4'd9);
    run_op(4'd2, 80, -1);
    check("dn_done_cyc", dcyc, 65);
    check("dn_steps", sdone, 7);
    check("dn_k2_pulses", p2, 7);
    check("dn_k2_low", low2, 28);
    check("dn_k1_pulses", p1, 0);
    check("dn_count", m_count, 2);
    check("dn_bad", bad, 0);

    set_count(4'd7);
    run_op(4'd7, 10, -1);
    check("eq_done_cyc", dcyc, 2);
    check("eq_steps", sdone, 0);
    check("eq_presses", p1 + p2, 0);
    check("eq_error", nerr, 0);

    set_count(4'd3);
    m_freeze = 1'b1;
    run_op(4'd8, 150, -1);
    m_freeze = 1'b0;
    check("frz_err_cyc", ecyc, 137);
    check("frz_nerr", nerr, 1);
    check("frz_ndone", ndone, 0);
    check("frz_steps", steps, 15);
    check("frz_k1_pulses", p1, 15);
    check("frz_bad", bad, 0);

    set_count(4'd0);
    @(negedge clk);
    start = 1'b1;
    target = 4'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_k1_low", key1, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_k1", key1, 1);
    check("rstmid_busy", busy, 0);
    rst = 1'b0;
    ndone = 0;
    nerr = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (error) nerr++;
    end
    check("rstmid_done", ndone, 0);
    check("rstmid_error", nerr, 0);
    check("rstmid_steps", steps, 0);

    set_count(4'd2);
    run_op(4'd6, 50, 10);
    check("busy_start_done_cyc", dcyc, 38);
    check("busy_start_ndone", ndone, 1);
    check("busy_start_steps", sdone, 4);
    check("busy_start_count", m_count, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
